// File: rtl/button_press_decoder.sv
// ---------------------------------------------------------------------------
// button_press_decoder
//   Turns one debounced button level into single-cycle classified events.
//   A press that is released before LONG_CNT cycles gives short_press_o.
//   Holding for LONG_CNT cycles gives long_press_o. Holding past that gives
//   repeat_o every REPEAT_CNT cycles. Every physical press produces exactly
//   one short or long event.
//
// Ports
//   clk_i          system clock; all logic changes on the rising edge
//   reset_i        synchronous, active-high reset
//   db_i           debounced button level, 1 = pressed
//   short_press_o  1-cycle pulse: released before the long threshold
//   long_press_o   1-cycle pulse: long threshold reached
//   repeat_o       1-cycle pulse every REPEAT_CNT cycles after long_press_o
//   held_o         level: a press is currently being tracked
// ---------------------------------------------------------------------------
module button_press_decoder #(
  parameter int CW         = 28,
  parameter int LONG_CNT   = 100_000_000,
  parameter int REPEAT_CNT = 20_000_000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic db_i,
  output logic short_press_o,
  output logic long_press_o,
  output logic repeat_o,
  output logic held_o
);

  typedef enum logic [1:0] {IDLE, PRESS, LONG} state_e;

  localparam logic [CW-1:0] LONG_TC = CW'(LONG_CNT - 1);
  localparam logic [CW-1:0] REP_TC  = CW'(REPEAT_CNT - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          db_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      // db_q resets high so that a button held through reset shows no
      // rising edge. It must be released and pressed again.
      db_q          <= 1'b1;
      short_press_o <= 1'b0;
      long_press_o  <= 1'b0;
      repeat_o      <= 1'b0;
      held_o        <= 1'b0;
    end else begin
      db_q          <= db_i;
      short_press_o <= 1'b0;
      long_press_o  <= 1'b0;
      repeat_o      <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (db_i && !db_q) begin
            state_q <= PRESS;
            held_o  <= 1'b1;
          end
        end
        PRESS: begin
          // A release wins over a terminal count that lands on the same edge.
          if (!db_i) begin
            short_press_o <= 1'b1;
            held_o        <= 1'b0;
            state_q       <= IDLE;
            cnt_q         <= '0;
          end else if (cnt_q == LONG_TC) begin
            long_press_o <= 1'b1;
            cnt_q        <= '0;
            state_q      <= LONG;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LONG: begin
          if (!db_i) begin
            held_o  <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == REP_TC) begin
            repeat_o <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          held_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_press_decoder.sv
module tb_button_press_decoder;
  localparam int CW  = 8;
  localparam int LNG = 10;
  localparam int REP = 4;

  logic clk_i = 1'b0;
  logic reset_i, db_i;
  logic short_press_o, long_press_o, repeat_o, held_o;

  button_press_decoder #(.CW(CW), .LONG_CNT(LNG), .REPEAT_CNT(REP)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .db_i(db_i),
    .short_press_o(short_press_o), .long_press_o(long_press_o),
    .repeat_o(repeat_o), .held_o(held_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Behavioural model: counts consecutive high samples since the press edge
  // and classifies the event from that length alone.
  bit mvalid = 0;
  bit trk = 0, prev = 1;
  int len = 0;
  bit e_short = 0, e_long = 0, e_rep = 0, e_held = 0;

  always @(posedge clk_i) begin
    e_short = 0; e_long = 0; e_rep = 0;
    if (reset_i) begin
      trk = 0; len = 0; prev = 1; e_held = 0; mvalid = 1;
    end else begin
      if (!trk) begin
        if (db_i && !prev) begin trk = 1; len = 1; end
      end else if (!db_i) begin
        if (len <= LNG) e_short = 1;
        trk = 0;
      end else begin
        if (len == LNG) e_long = 1;
        else if (len > LNG && ((len - LNG) % REP) == 0) e_rep = 1;
        len++;
      end
      prev = db_i;
      e_held = trk;
    end
  end

  // Per-cycle compare against the model, plus monotonic event counters.
  int n_short = 0, n_long = 0, n_rep = 0, n_held = 0, cyc = 0;
  int last_short = 0, prev_short = 0;

  always @(negedge clk_i) begin
    cyc++;
    if (mvalid) begin
      checks++;
      if ({short_press_o, long_press_o, repeat_o, held_o} !==
          {e_short, e_long, e_rep, e_held}) begin
        errors++;
        $display("FAIL model cyc=%0d got s/l/r/h=%b%b%b%b want %b%b%b%b", cyc,
                 short_press_o, long_press_o, repeat_o, held_o,
                 e_short, e_long, e_rep, e_held);
      end
    end
    if (short_press_o === 1'b1) begin n_short++; prev_short = last_short; last_short = cyc; end
    if (long_press_o === 1'b1) n_long++;
    if (repeat_o === 1'b1) n_rep++;
    if (held_o === 1'b1) n_held++;
  end

  int b_s, b_l, b_r, b_h;

  task automatic step(input bit r, input bit d, input int n);
    reset_i = r; db_i = d;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic mark();
    b_s = n_short; b_l = n_long; b_r = n_rep; b_h = n_held;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic chk_ev(input string name, input int s, input int l, input int r, input int h);
    chk({name, ".short"}, n_short - b_s, s);
    chk({name, ".long"},  n_long - b_l, l);
    chk({name, ".rep"},   n_rep - b_r, r);
    if (h >= 0) chk({name, ".held"}, n_held - b_h, h);
  endtask

  initial begin
    reset_i = 1; db_i = 1;
    // 1: held through reset is ignored
    step(1, 1, 3);
    chk("rst.outs", {short_press_o, long_press_o, repeat_o, held_o}, 0);
    mark();
    step(0, 1, 20);
    chk_ev("held_thru_rst", 0, 0, 0, 0);
    step(0, 0, 1);
    step(0, 1, 1);
    chk("repress.held", held_o, 1);
    step(0, 1, 2);
    step(0, 0, 3);

    // 2: short press, 5 high samples
    mark();
    step(0, 1, 5); step(0, 0, 3);
    chk_ev("short5", 1, 0, 0, 5);

    // 3: threshold boundary
    mark();
    step(0, 1, 10); step(0, 0, 3);
    chk_ev("hi10", 1, 0, 0, 10);
    mark();
    step(0, 1, 11); step(0, 0, 3);
    chk_ev("hi11", 0, 1, 0, 11);

    // 4: auto-repeat, release coincides with a terminal count
    mark();
    step(0, 1, 30); step(0, 0, 3);
    chk_ev("hi30", 0, 1, 4, 30);

    // 5: reset mid-LONG with db held
    mark();
    step(0, 1, 15);
    step(1, 1, 1);
    chk("midrst.outs", {short_press_o, long_press_o, repeat_o, held_o}, 0);
    mark();
    step(0, 1, 20);
    chk_ev("after_midrst", 0, 0, 0, 0);
    step(0, 0, 1);
    step(0, 1, 1);
    chk("midrst.repress", held_o, 1);
    step(0, 0, 3);

    // 6: single-sample press and back-to-back presses
    mark();
    step(0, 1, 1); step(0, 0, 3);
    chk_ev("single", 1, 0, 0, 1);
    mark();
    step(0, 1, 1); step(0, 0, 1); step(0, 1, 1); step(0, 0, 3);
    chk_ev("b2b", 2, 0, 0, 2);
    chk("b2b.gap", last_short - prev_short, 2);

    // Randomised runs checked by the model every cycle
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(99) < 3) step(1, 1'($urandom_range(1)), $urandom_range(1, 2));
      else step(0, 1'(i % 2), $urandom_range(1, 35));
    end
    step(0, 0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/button_press_decoder.md
# button_press_decoder

Downstream consumer of the debouncer's clean `db` level. It converts one debounced button level into single-cycle event pulses: `short_press` on release before the long-press threshold, `long_press` when the threshold is crossed, and periodic `repeat` pulses while the button stays held. The control FSMs (digit/field editing, menu navigation) consume these pulses directly, so each physical press produces exactly one classified event.

## Interface
Parameters:
- `CW`, 28, width of the hold counter; must satisfy `LONG_CNT < 2^CW` and `REPEAT_CNT < 2^CW`.
- `LONG_CNT`, 100_000_000, number of cycles the button must be held to count as a long press (1 s at the 10 ns system clock); legal range ≥ 2.
- `REPEAT_CNT`, 20_000_000, auto-repeat period in cycles after a long press (200 ms); legal range ≥ 2.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `db`  in  1  debounced button level, synchronous to `clk`, 1 = pressed.
- `short_press`  out  1  one-cycle pulse: released before the long threshold.
- `long_press`  out  1  one-cycle pulse: long threshold reached.
- `repeat`  out  1  one-cycle pulse every `REPEAT_CNT` cycles after `long_press`.
- `held`  out  1  level: a press is currently being tracked.

## Operation
- All outputs are registered. `db_q` is a one-cycle delayed copy of `db`, used to detect the press edge.
- On reset: `short_press`, `long_press`, `repeat` and `held` are 0; state is IDLE; `cnt` is 0; `db_q` is 1.
  - Because `db_q` resets to 1, a button held through reset is ignored. It must be released and pressed again.
- `reset` has priority over every other event.

States:
- **IDLE**
  - `db & ~db_q`: go to PRESS, `cnt <= 0`, `held <= 1`.
  - Otherwise: stay in IDLE.
- **PRESS**
  - `~db`: `short_press <= 1`, `held <= 0`, go to IDLE.
  - Else if `cnt == LONG_CNT-1`: `long_press <= 1`, `cnt <= 0`, go to LONG.
  - Otherwise: `cnt <= cnt+1`.
  - Release takes priority over a simultaneous terminal count, so the event is `short_press`.
- **LONG**
  - `~db`: `held <= 0`, go to IDLE, no pulse.
  - Else if `cnt == REPEAT_CNT-1`: `repeat <= 1`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - Release takes priority over a simultaneous terminal count, so no `repeat` is emitted.

Counter and outputs:
- `cnt` never exceeds its terminal value, so there is no wrap-around. It is held at 0 in IDLE.
- The three pulse outputs are mutually exclusive and default to 0 every cycle.
- `held` is 1 exactly while in PRESS or LONG.
- A new press is recognised only from IDLE. Once released, the block returns to IDLE in the same edge, so back-to-back presses separated by one low sample are each classified.

## Timing
- Let edge k be the first rising edge that samples `db=1` with `db_q=0` in IDLE.
- `held` rises in the cycle after edge k.
- `long_press` goes high for one cycle after edge k+`LONG_CNT`, provided `db` was sampled 1 at edges k..k+`LONG_CNT`.
- `repeat` pulses after edges k+`LONG_CNT`+n·`REPEAT_CNT`, for n ≥ 1, while `db` stays sampled 1.
- Release edge r (first edge sampling `db=0`):
  - From PRESS: `short_press` goes high for one cycle after edge r.
  - From both PRESS and LONG: `held` falls after edge r.
- Latency from a `db` change to the corresponding output is 1 cycle.
- Minimum classifiable press is a single sample of `db=1`.

## Test plan
Bench parameters: `CW`=8, `LONG_CNT`=10, `REPEAT_CNT`=4.

1. **Reset / held through reset:** assert `reset` 3 cycles with `db=1`, then keep `db=1` for 20 cycles → all outputs stay 0. Then drop `db` 1 cycle and raise it again → `held` rises 1 cycle after the re-press edge.
2. **Short press:** `db` sampled 1 for 5 edges, then 0 → `held`=1 for 5 cycles; one `short_press` pulse after the release edge; `long_press`=`repeat`=0.
3. **Threshold boundary:**
   - `db` sampled 1 on exactly 10 edges (k..k+9), 0 at k+10 → `short_press` after k+10, no `long_press`.
   - Repeat with 11 high samples → `long_press` after k+10, no `short_press` on release.
4. **Auto-repeat with coincident release:** `db` sampled 1 on edges k..k+29, 0 at k+30 →
   - `long_press` after k+10;
   - `repeat` after k+14, k+18, k+22 and k+26 (4 pulses);
   - no pulse at k+30;
   - `held` falls after k+30.
5. **Reset mid-LONG:** hold 15 cycles, then assert `reset` 1 cycle while `db` stays 1 → all outputs 0 the next cycle. No further pulses occur until `db` drops and rises again.
6. **Single-sample press and back-to-back presses:**
   - `db`=1 for exactly one edge → `held` high 1 cycle, then one `short_press`.
   - Pattern 1,0,1,0 (one edge each) → two separate `short_press` pulses, 2 cycles apart.
